mcs4_rom_loader: RTL
====================

Name: mcs4_rom_loader

Overview:
Host-side sequencer that fills the i4001 ROM images over their shared debug write port (dbg_addr/dbg_wdata/dbg_wen) from a byte stream supplied by the PS.
It is started by a host command, walks a linear address range across chip IDs, and holds the CPU in reset while it loads.
It is the only driver of the debug write bus; all ROM instances decode chip ID from dbg_addr[2].

Parameters:
NUM_ROMS, 16, number of ROM chip IDs that are populated (1..16); legal byte space is NUM_ROMS*256.
HOLD_TAIL, 2, clock cycles cpu_rst_hold stays asserted after the last write is issued.

Ports:
clk  input  1  system clock.
rst  input  1  reset, asynchronous, active-high.
start  input  1  single-cycle load command; sampled only in IDLE.
abort  input  1  terminate the load in progress; no done pulse.
base_rom  input  4  (mcs4::char_t) first chip ID to write.
num_bytes  input  13  byte count, 0..4096.
s_data  input  8  (mcs4::byte_t) stream byte.
s_valid  input  1  s_data valid.
s_ready  output  1  loader accepts s_data this cycle.
dbg_addr  output  3x4  (mcs4::char_t [2:0]) {chip ID, addr hi nibble, addr lo nibble}.
dbg_wdata  output  8  (mcs4::byte_t) write data.
dbg_wen  output  1  write strobe, one cycle per byte.
cpu_rst_hold  output  1  hold CPU/ROM-sequencing logic in reset.
busy  output  1  state != IDLE.
done  output  1  one-cycle pulse on successful completion.
err  output  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset (async): state=IDLE. s_ready, dbg_wen, done, err, cpu_rst_hold, busy all 0. dbg_addr and dbg_wdata 0. Counters 0.
- State IDLE:
  - start with base_rom*256 + num_bytes > NUM_ROMS*256: err pulses the next cycle; stay in IDLE.
  - start with num_bytes==0 (and in range): go to TAIL. No writes are issued.
  - Otherwise: latch a 12-bit address counter = {base_rom, 8'h00} and remain = num_bytes; go to LOAD. cpu_rst_hold rises the cycle after start.
- State LOAD:
  - s_ready = 1 combinationally while remain != 0.
  - Handshake: s_valid && s_ready. The cycle after a handshake, dbg_wen=1, dbg_wdata=byte, dbg_addr = {addr[11:8], addr[7:4], addr[3:0]}. Write latency is 1 cycle.
  - On each handshake, addr increments by 1 and remain decrements by 1. Carry from addr[7:0] moves to the next chip ID.
  - Back-to-back handshakes give one write per cycle.
  - s_valid low leaves all state unchanged and dbg_wen=0.
  - When the handshake takes remain to 0: go to TAIL. The final dbg_wen is issued in the first TAIL cycle.
- State TAIL:
  - s_ready=0, cpu_rst_hold=1.
  - Count HOLD_TAIL cycles, then go to IDLE.
  - On the transition to IDLE: done pulses 1 cycle, and cpu_rst_hold falls in the same cycle done is high.
- abort (any non-IDLE state):
  - Next cycle: state=IDLE, s_ready=0, cpu_rst_hold=0, no done, no err.
  - A handshake in the abort cycle is discarded; dbg_wen is not issued for it.
  - abort has priority over a same-cycle handshake.
- start while busy is ignored; start and abort together in IDLE are treated as start.
- Address wrap past chip ID 15 cannot occur, because the range check rejects it.
- busy = (state != IDLE), registered.

Optional Feature:
Macro ROM_LOADER_CKSUM_EN.
- When defined:
  - Adds output cksum (8 bits). It is cleared on an accepted start and adds each written byte mod 256 in the cycle its dbg_wen is issued.
  - Final value is stable from the done pulse until the next accepted start; it is 0 after reset.
- When undefined: the port and the adder are absent, and all other behaviour is identical.

Test Plan:
- Reset mid-LOAD after 5 of 10 bytes -> all outputs 0 immediately; the next start with base_rom=0, num_bytes=1 writes addr {0,0,0}.
- base_rom=2, num_bytes=3, bytes A5,3C,FF streamed back-to-back -> dbg_wen on 3 consecutive cycles at {2,0,0},{2,0,1},{2,0,2}; done pulses HOLD_TAIL+1 cycles after the last write; cpu_rst_hold falls with done.
- base_rom=0, num_bytes=258, s_valid toggling every other cycle -> write 256 goes to {0,F,F}, write 257 to {1,0,0}, write 258 to {1,0,1}; exactly 258 dbg_wen pulses.
- NUM_ROMS=4, base_rom=3, num_bytes=257 -> err pulse; no dbg_wen; busy stays 0. Then num_bytes=256 -> accepted, last write at {3,F,F}.
- abort during the 4th handshake of an 8-byte load -> exactly 3 dbg_wen; no done; cpu_rst_hold=0 the next cycle; a later start is accepted.
- num_bytes=0 -> no dbg_wen; done after HOLD_TAIL+1 cycles. With ROM_LOADER_CKSUM_EN, bytes 80,80,01 -> cksum=01 at done.

Source files
------------

// File: rtl/mcs4_rom_loader.sv
// Streams a host byte sequence into the i4001 ROM images over the shared debug write port,
// holding the CPU in reset for the duration. Optional checksum output: define ROM_LOADER_CKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start; range-checks the command
// LOAD  | accepting stream bytes, one debug write per handshake
// TAIL  | last write drained, counting HOLD_TAIL before releasing the CPU
module mcs4_rom_loader #(
    parameter int NUM_ROMS  = 16,
    parameter int HOLD_TAIL = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [3:0]      base_rom,
    input  logic [12:0]     num_bytes,
    input  logic [7:0]      s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic [2:0][3:0] dbg_addr,
    output logic [7:0]      dbg_wdata,
    output logic            dbg_wen,
    output logic            cpu_rst_hold,
    output logic            busy,
    output logic            done,
    output logic            err
`ifdef ROM_LOADER_CKSUM_EN
    ,
    output logic [7:0]      cksum
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, TAIL} state_t;

    localparam int          TW    = $clog2(HOLD_TAIL + 2);
    localparam logic [13:0] LIMIT = 14'(NUM_ROMS * 256);

    state_t        state;
    logic [11:0]   addr;
    logic [12:0]   remain;
    logic [TW-1:0] tail_cnt;
    logic [13:0]   req_end;
    logic          hs;

    // End of the requested byte range; must not exceed the populated ROM space.
    assign req_end = {2'b00, base_rom, 8'h00} + {1'b0, num_bytes};
    assign s_ready = (state == LOAD) && (remain != '0);
    assign hs      = s_valid && s_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            addr         <= '0;
            remain       <= '0;
            tail_cnt     <= '0;
            dbg_addr     <= '0;
            dbg_wdata    <= '0;
            dbg_wen      <= 1'b0;
            cpu_rst_hold <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
`ifdef ROM_LOADER_CKSUM_EN
            cksum        <= '0;
`endif
        end else begin
            dbg_wen <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (req_end > LIMIT) begin
                            err <= 1'b1;
                        end else begin
                            addr         <= {base_rom, 8'h00};
                            remain       <= num_bytes;
                            cpu_rst_hold <= 1'b1;
                            busy         <= 1'b1;
`ifdef ROM_LOADER_CKSUM_EN
                            cksum        <= '0;
`endif
                            if (num_bytes == '0) begin
                                state    <= TAIL;
                                tail_cnt <= TW'(HOLD_TAIL);
                            end else begin
                                state    <= LOAD;
                            end
                        end
                    end
                end
                LOAD: begin
                    // abort wins over a same-cycle handshake, so that byte is dropped
                    if (abort) begin
                        state        <= IDLE;
                        remain       <= '0;
                        cpu_rst_hold <= 1'b0;
                        busy         <= 1'b0;
                    end else if (hs) begin
                        dbg_wen   <= 1'b1;
                        dbg_wdata <= s_data;
                        dbg_addr  <= {addr[11:8], addr[7:4], addr[3:0]};
                        addr      <= addr + 12'd1;
                        remain    <= remain - 13'd1;
`ifdef ROM_LOADER_CKSUM_EN
                        cksum     <= cksum + s_data;
`endif
                        if (remain == 13'd1) begin
                            state    <= TAIL;
                            tail_cnt <= TW'(HOLD_TAIL);
                        end
                    end
                end
                TAIL: begin
                    if (abort) begin
                        state        <= IDLE;
                        cpu_rst_hold <= 1'b0;
                        busy         <= 1'b0;
                    end else if (tail_cnt == '0) begin
                        state        <= IDLE;
                        done         <= 1'b1;
                        cpu_rst_hold <= 1'b0;
                        busy         <= 1'b0;
                    end else begin
                        tail_cnt <= tail_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
